// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default buffer depth and the
// odd-parity helper used by the receive-side buffer.
package uart_pkg;

    localparam int UART_DATA_W             = 8;
    localparam int UART_FRAME_W            = 9;
    localparam int UART_FIFO_DEPTH_DEFAULT = 16;

    // A frame is good when the nine bits together carry odd parity.
    function automatic logic uart_parity_ok(input logic [UART_FRAME_W-1:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO. Pointers carry one extra
// wrap bit so full and empty can be told apart; Level is registered.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic             Clk,
    input  logic             Rstn,
    input  logic             WrEn,
    input  logic [WIDTH-1:0] WrData,
    input  logic             RdEn,
    output logic [WIDTH-1:0] RdData,
    output logic             Empty,
    output logic             Full,
    output logic [PW-1:0]    Level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtrNext;
    logic [PW-1:0]    rdPtrNext;
    logic             doWrite;
    logic             doRead;

    assign Empty   = (wrPtr == rdPtr);
    assign Full    = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
    assign doRead  = RdEn && !Empty;
    assign doWrite = WrEn && (!Full || doRead);
    assign RdData  = Empty ? '0 : mem[rdPtr[AW-1:0]];

    // Advance each pointer by one when its side of the FIFO fires.
    always_comb begin
        wrPtrNext = wrPtr + PW'(doWrite);
        rdPtrNext = rdPtr + PW'(doRead);
    end

    // Pointer and occupancy registers; reset drops all stored entries at once.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Level <= '0;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
            Level <= wrPtrNext - rdPtrNext;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge Clk) begin
        if (doWrite) begin
            mem[wrPtr[AW-1:0]] <= WrData;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART core: drops frames on overflow, keeps
// sticky flags and saturating counters. Define RX_PARITY_CHECK_EN to also
// drop and count frames that fail the odd-parity check.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEFAULT,
    parameter int CNT_W = 8,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic                    Clk,
    input  logic                    Rstn,
    input  logic [UART_FRAME_W-1:0] RxFrame,
    input  logic                    RxFrameValid,
    output logic [UART_DATA_W-1:0]  RdData,
    output logic                    RdValid,
    input  logic                    RdReady,
    output logic [LW-1:0]           Level,
    output logic                    ParityErr,
    output logic                    Overflow,
    output logic [CNT_W-1:0]        ParErrCnt,
    output logic [CNT_W-1:0]        OvfCnt,
    input  logic                    ClrStat
);

    logic fifoEmpty;
    logic fifoFull;
    logic popFire;
    logic hasSpace;
    logic frameGood;
    logic pushFire;
    logic ovfEvent;

    assign RdValid  = !fifoEmpty;
    assign popFire  = !fifoEmpty && RdReady;
    assign hasSpace = !fifoFull || popFire;
    assign pushFire = RxFrameValid && frameGood && hasSpace;
    assign ovfEvent = RxFrameValid && frameGood && !hasSpace;

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) uFifo (
        .Clk    (Clk),
        .Rstn   (Rstn),
        .WrEn   (pushFire),
        .WrData (RxFrame[UART_DATA_W-1:0]),
        .RdEn   (RdReady),
        .RdData (RdData),
        .Empty  (fifoEmpty),
        .Full   (fifoFull),
        .Level  (Level)
    );

`ifdef RX_PARITY_CHECK_EN
    logic parEvent;

    assign frameGood = uart_parity_ok(RxFrame);
    assign parEvent  = RxFrameValid && !frameGood;

    // Parity statistics; a clear in the same cycle wins over a new error.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            ParityErr <= 1'b0;
            ParErrCnt <= '0;
        end else if (ClrStat) begin
            ParityErr <= 1'b0;
            ParErrCnt <= '0;
        end else if (parEvent) begin
            ParityErr <= 1'b1;
            if (ParErrCnt != '1) begin
                ParErrCnt <= ParErrCnt + CNT_W'(1);
            end
        end
    end
`else
    logic unusedParityBit;

    assign frameGood       = 1'b1;
    assign ParityErr       = 1'b0;
    assign ParErrCnt       = '0;
    assign unusedParityBit = RxFrame[UART_FRAME_W-1];
`endif

    // Overflow statistics; a clear in the same cycle wins over a new drop.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            Overflow <= 1'b0;
            OvfCnt   <= '0;
        end else if (ClrStat) begin
            Overflow <= 1'b0;
            OvfCnt   <= '0;
        end else if (ovfEvent) begin
            Overflow <= 1'b1;
            if (OvfCnt != '1) begin
                OvfCnt <= OvfCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. Expected bytes go into a scoreboard
// queue when a frame is driven; a monitor pops and compares on every read
// handshake. Expectations follow RX_PARITY_CHECK_EN when it is defined.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
    localparam int LW    = 5;

    logic             clock = 1'b0;
    logic             resetN;
    logic [8:0]       rxFrame;
    logic             rxFrameValid;
    logic [7:0]       rdData;
    logic             rdValid;
    logic             rdReady;
    logic [LW-1:0]    level;
    logic             parityErr;
    logic             overflow;
    logic [CNT_W-1:0] parErrCnt;
    logic [CNT_W-1:0] ovfCnt;
    logic             clrStat;

    int         testsRun    = 0;
    int         testsFailed = 0;
    logic [7:0] expQ [$];
    logic [7:0] monExp;
    int         modelParCnt = 0;
    int         modelOvfCnt = 0;
    logic       modelPar    = 1'b0;
    logic       modelOvf    = 1'b0;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .Clk          (clock),
        .Rstn         (resetN),
        .RxFrame      (rxFrame),
        .RxFrameValid (rxFrameValid),
        .RdData       (rdData),
        .RdValid      (rdValid),
        .RdReady      (rdReady),
        .Level        (level),
        .ParityErr    (parityErr),
        .Overflow     (overflow),
        .ParErrCnt    (parErrCnt),
        .OvfCnt       (ovfCnt),
        .ClrStat      (clrStat)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Safety net so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: each read handshake must deliver the oldest expected byte.
    always @(negedge clock) begin
        if (resetN && rdValid && rdReady) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedPop: got 0x%0h, expected no data", rdData);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("rdData", {24'h0, rdData}, {24'h0, monExp});
            end
        end
    end

    function automatic logic [8:0] goodFrame(input logic [7:0] d);
        return {~^d, d};
    endfunction

    // Drive one frame for one cycle and update the scoreboard and stat model.
    task automatic applyStimulus(input logic [8:0] frame, input logic clr);
        logic good;
        logic pop;
`ifdef RX_PARITY_CHECK_EN
        good = ^frame;
`else
        good = 1'b1;
`endif
        pop          = rdReady && (expQ.size() > 0);
        rxFrame      = frame;
        rxFrameValid = 1'b1;
        clrStat      = clr;
        if (clr) begin
            modelPar    = 1'b0;
            modelOvf    = 1'b0;
            modelParCnt = 0;
            modelOvfCnt = 0;
        end
        if (good && (expQ.size() < DEPTH || pop)) begin
            expQ.push_back(frame[7:0]);
        end else if (good && !clr) begin
            modelOvf = 1'b1;
            if (modelOvfCnt < 255) modelOvfCnt++;
        end
        if (!good && !clr) begin
            modelPar = 1'b1;
            if (modelParCnt < 255) modelParCnt++;
        end
        @(posedge clock);
        #1;
        rxFrameValid = 1'b0;
        clrStat      = 1'b0;
        rxFrame      = '0;
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, ".parityErr"}, {31'h0, parityErr}, {31'h0, modelPar});
        checkOutput({tag, ".overflow"}, {31'h0, overflow}, {31'h0, modelOvf});
        checkOutput({tag, ".parErrCnt"}, {24'h0, parErrCnt}, modelParCnt);
        checkOutput({tag, ".ovfCnt"}, {24'h0, ovfCnt}, modelOvfCnt);
    endtask

    // Hold RdReady until the scoreboard empties, with a cycle bound.
    task automatic drain(input string tag);
        rdReady = 1'b1;
        for (int i = 0; i < 64 && expQ.size() > 0; i++) begin
            @(posedge clock);
            #1;
        end
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s.drainTimeout: got %0d left, expected 0", tag, expQ.size());
            expQ.delete();
        end
        rdReady = 1'b0;
        checkOutput({tag, ".rdValidEmpty"}, {31'h0, rdValid}, 32'h0);
        checkOutput({tag, ".levelEmpty"}, {27'h0, level}, 32'h0);
    endtask

    // Directed sequence.
    initial begin
        resetN       = 1'b0;
        rxFrame      = '0;
        rxFrameValid = 1'b0;
        rdReady      = 1'b0;
        clrStat      = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock);
        #1;

        checkOutput("reset.rdValid", {31'h0, rdValid}, 32'h0);
        checkOutput("reset.level", {27'h0, level}, 32'h0);
        checkOutput("reset.rdData", {24'h0, rdData}, 32'h0);
        checkStats("reset");

        applyStimulus(9'h100, 1'b0);
        checkOutput("first.rdValid", {31'h0, rdValid}, 32'h1);
        checkOutput("first.rdData", {24'h0, rdData}, 32'h0);
        checkOutput("first.level", {27'h0, level}, 32'h1);
        drain("first");

        applyStimulus(9'h000, 1'b0);
`ifdef RX_PARITY_CHECK_EN
        checkOutput("badPar.parityErr", {31'h0, parityErr}, 32'h1);
        checkOutput("badPar.parErrCnt", {24'h0, parErrCnt}, 32'h1);
        checkOutput("badPar.level", {27'h0, level}, 32'h0);
`else
        checkOutput("badPar.parErrCnt", {24'h0, parErrCnt}, 32'h0);
        checkOutput("badPar.level", {27'h0, level}, 32'h1);
`endif
        checkStats("badPar");
        drain("badPar");

        for (int i = 1; i <= 16; i++) applyStimulus(goodFrame(8'(i)), 1'b0);
        checkOutput("fill.level", {27'h0, level}, 32'd16);
        applyStimulus(goodFrame(8'h11), 1'b0);
        checkOutput("ovf.level", {27'h0, level}, 32'd16);
        checkOutput("ovf.overflow", {31'h0, overflow}, 32'h1);
        checkStats("ovf");
        drain("ovf");

        for (int i = 0; i < 16; i++) applyStimulus(goodFrame(8'h20 + 8'(i)), 1'b0);
        rdReady = 1'b1;
        applyStimulus(goodFrame(8'h30), 1'b0);
        rdReady = 1'b0;
        checkOutput("pushPop.level", {27'h0, level}, 32'd16);
        checkStats("pushPop");
        drain("pushPop");

        for (int i = 0; i < 300; i++) applyStimulus(9'h000, 1'b0);
        checkStats("sat");
`ifdef RX_PARITY_CHECK_EN
        checkOutput("sat.parErrCntMax", {24'h0, parErrCnt}, 32'd255);
`endif
        applyStimulus(9'h000, 1'b1);
        checkOutput("clr.parErrCnt", {24'h0, parErrCnt}, 32'h0);
        checkOutput("clr.parityErr", {31'h0, parityErr}, 32'h0);
        checkStats("clr");
        drain("clr");

        for (int i = 0; i < 5; i++) applyStimulus(goodFrame(8'h40 + 8'(i)), 1'b0);
        checkOutput("preRst.level", {27'h0, level}, 32'd5);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("asyncRst.rdValid", {31'h0, rdValid}, 32'h0);
        checkOutput("asyncRst.level", {27'h0, level}, 32'h0);
        expQ.delete();
        modelPar    = 1'b0;
        modelOvf    = 1'b0;
        modelParCnt = 0;
        modelOvfCnt = 0;
        checkStats("asyncRst");
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(9'h1A5, 1'b0);
        checkOutput("postRst.rdData", {24'h0, rdData}, 32'hA5);
        checkOutput("postRst.level", {27'h0, level}, 32'h1);
        drain("postRst");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
